pad_frame_bridge: RTL and testbench
===================================

# pad_frame_bridge

Parametrised pad-side bridge that sits between the chip pad ring and the compute core, in place of direct pad-to-core wiring. Captures a contiguous input burst (one frame) from the pads into a local buffer, replays it to the core over a valid/ready handshake, and registers the core's result stream back out to the output pads. Widths, buffer depth and output zeroing are parameters, so one block serves every lab core.

## Interface
- IN_W, 14, pad input word width (e.g. x, y, move count, priority concatenated)
- OUT_W, 11, output word width
- DEPTH, 32, frame buffer depth in words (≥2)
- ZERO_IDLE, 1, 1: pad_out_data forced to 0 whenever pad_out_valid is 0
- LW = $clog2(DEPTH+1), derived width of frame length

- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- pad_in_valid  in  1  input burst qualifier
- pad_in_data  in  IN_W  input word
- core_in_valid  out  1  buffered word available to core
- core_in_data  out  IN_W  buffered word
- core_in_last  out  1  high with final word of frame
- core_in_ready  in  1  core accepts word
- core_out_valid  in  1  core result qualifier
- core_out_data  in  OUT_W  core result word
- pad_out_valid  out  1  registered result qualifier to pads
- pad_out_data  out  OUT_W  registered result word to pads
- frame_len  out  LW  words stored in current frame
- overflow  out  1  sticky: frame exceeded DEPTH
- protocol_err  out  1  sticky: pad_in_valid outside IDLE/CAPTURE
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, CAPTURE, DRAIN, WAIT_OUT.
- IDLE: pad_in_valid=1 → write word to slot 0, frame_len←1, clear overflow and protocol_err, → CAPTURE.
- CAPTURE: each cycle with pad_in_valid=1 and frame_len<DEPTH writes slot frame_len, frame_len+1. With frame_len=DEPTH, word dropped, overflow←1. pad_in_valid=0 → rd_ptr←0, → DRAIN.
- DRAIN: core_in_valid=1, core_in_data=mem[rd_ptr], core_in_last=(rd_ptr==frame_len-1). Transfer on valid&ready, rd_ptr+1. Data and last held stable while ready=0. Transfer with last → WAIT_OUT.
- WAIT_OUT: waits for core result; leaves to IDLE on the cycle after core_out_valid falls from 1 to 0 (at least one result word seen).
- pad_in_valid=1 in DRAIN or WAIT_OUT: word ignored, protocol_err←1, no state change.
- Output path independent of state: pad_out_valid←core_out_valid, pad_out_data←core_out_data (or 0 when ZERO_IDLE and core_out_valid=0).
- frame_len holds after capture until next frame start.

## Timing
- Reset: state IDLE; core_in_valid, core_in_last, core_in_data, pad_out_valid, pad_out_data, frame_len, overflow, protocol_err, busy all 0. Asynchronous assert, synchronous-release usage assumed by the chip-level reset synchroniser.
- Reset mid-operation: frame discarded, all outputs to reset values immediately.
- Capture: word on cycle t stored at edge t.
- core_in_valid rises the cycle after the first cycle with pad_in_valid=0 (frame of N words: first core word N+1 cycles after first pad word).
- Back-to-back transfers with ready=1: one word per cycle, no bubbles.
- Output latency: exactly 1 cycle, core_out to pad_out.
- busy=1 from cycle after frame start until IDLE re-entered.
- Single-word frame: core_in_last=1 on first word.

## Structure
- Package pad_bridge_pkg: state enum (IDLE, CAPTURE, DRAIN, WAIT_OUT), default width/depth constants, LW helper function.
- Sub-module frame_buffer_mem: DEPTH×IN_W register file, one synchronous write port, one asynchronous read port; no reset on storage.
- FSM, pointers, sticky flags and output register in top level.

## Test plan
- 5-word frame 0x0101..0x0105, ready=1 → core sees 5 words in 5 consecutive cycles, last on 0x0105, frame_len=5, overflow=0.
- Same frame, ready toggling 1,0,0,1,… → each word held until accepted, order preserved, last only on 5th.
- DEPTH+3 words → first DEPTH words delivered, overflow=1, frame_len=DEPTH; next frame start clears overflow.
- core_out_valid high 3 cycles with 0x011,0x022,0x033 → pad_out same values one cycle later, pad_out_data=0 otherwise, IDLE one cycle after valid falls.
- rst pulsed during DRAIN at word 2 → all outputs 0 at once, busy=0, new frame after release captured from slot 0.
- pad_in_valid pulse during WAIT_OUT → no state change, protocol_err=1, word not delivered.

Source files
------------

// File: rtl/pad_bridge_pkg.sv
// Shared types and sizing helpers for the pad-side frame bridge.
package pad_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURE  = 2'd1,
    DRAIN    = 2'd2,
    WAIT_OUT = 2'd3
  } state_e;

  localparam int unsigned IN_W_DEF  = 14;
  localparam int unsigned OUT_W_DEF = 11;
  localparam int unsigned DEPTH_DEF = 32;

  function automatic int unsigned len_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/frame_buffer_mem.sv
// Frame storage: one synchronous write port, one asynchronous read port.
// Storage is deliberately not reset; the read side is gated by the bridge.
module frame_buffer_mem #(
  parameter int unsigned DATA_W = 14,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned AW     = 5
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pad_frame_bridge.sv
// Captures one pad input burst, replays it to the core over valid/ready,
// and registers the core result stream back out to the pads.
module pad_frame_bridge
  import pad_bridge_pkg::*;
#(
  parameter int unsigned IN_W      = IN_W_DEF,
  parameter int unsigned OUT_W     = OUT_W_DEF,
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter bit          ZERO_IDLE = 1'b1,
  localparam int unsigned LW       = len_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pad_in_valid,
  input  logic [IN_W-1:0]  pad_in_data,
  output logic             core_in_valid,
  output logic [IN_W-1:0]  core_in_data,
  output logic             core_in_last,
  input  logic             core_in_ready,
  input  logic             core_out_valid,
  input  logic [OUT_W-1:0] core_out_data,
  output logic             pad_out_valid,
  output logic [OUT_W-1:0] pad_out_data,
  output logic [LW-1:0]    frame_len,
  output logic             overflow,
  output logic             protocol_err,
  output logic             busy
);

  localparam int unsigned AW = addr_width(DEPTH);

  state_e           state_q;
  logic [LW-1:0]    frame_len_q;
  logic [LW-1:0]    rd_ptr_q;
  logic             overflow_q;
  logic             perr_q;
  logic             seen_q;
  logic             pad_out_valid_q;
  logic [OUT_W-1:0] pad_out_data_q;
  logic [OUT_W-1:0] pad_out_data_d;

  logic             mem_we;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_addr;
  logic [IN_W-1:0]  rd_data;
  logic             in_drain;
  logic             last_word;
  logic             frame_full;

  assign frame_full = (frame_len_q == LW'(DEPTH));
  assign in_drain   = (state_q == DRAIN);
  assign last_word  = ((rd_ptr_q + LW'(1)) == frame_len_q);

  // The first word of a frame always lands in slot 0, whatever the old length.
  assign mem_we  = pad_in_valid &&
                   ((state_q == IDLE) || ((state_q == CAPTURE) && !frame_full));
  assign wr_addr = (state_q == IDLE) ? '0 : frame_len_q[AW-1:0];
  assign rd_addr = rd_ptr_q[AW-1:0];

  assign pad_out_data_d = (ZERO_IDLE && !core_out_valid) ? '0 : core_out_data;

  frame_buffer_mem #(
    .DATA_W (IN_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wr_addr),
    .wdata_i (pad_in_data),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      frame_len_q     <= '0;
      rd_ptr_q        <= '0;
      overflow_q      <= 1'b0;
      perr_q          <= 1'b0;
      seen_q          <= 1'b0;
      pad_out_valid_q <= 1'b0;
      pad_out_data_q  <= '0;
    end else begin
      pad_out_valid_q <= core_out_valid;
      pad_out_data_q  <= pad_out_data_d;

      case (state_q)
        IDLE: begin
          if (pad_in_valid) begin
            frame_len_q <= LW'(1);
            overflow_q  <= 1'b0;
            perr_q      <= 1'b0;
            state_q     <= CAPTURE;
          end
        end

        CAPTURE: begin
          if (pad_in_valid) begin
            if (frame_full) begin
              overflow_q <= 1'b1;
            end else begin
              frame_len_q <= frame_len_q + LW'(1);
            end
          end else begin
            rd_ptr_q <= '0;
            state_q  <= DRAIN;
          end
        end

        DRAIN: begin
          if (pad_in_valid) begin
            perr_q <= 1'b1;
          end
          if (core_in_ready) begin
            if (last_word) begin
              seen_q  <= 1'b0;
              state_q <= WAIT_OUT;
            end else begin
              rd_ptr_q <= rd_ptr_q + LW'(1);
            end
          end
        end

        WAIT_OUT: begin
          if (pad_in_valid) begin
            perr_q <= 1'b1;
          end
          // Leave only after a result burst has been seen and has ended.
          if (core_out_valid) begin
            seen_q <= 1'b1;
          end else if (seen_q) begin
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign core_in_valid = in_drain;
  assign core_in_data  = in_drain ? rd_data : '0;
  assign core_in_last  = in_drain && last_word;
  assign pad_out_valid = pad_out_valid_q;
  assign pad_out_data  = pad_out_data_q;
  assign frame_len     = frame_len_q;
  assign overflow      = overflow_q;
  assign protocol_err  = perr_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_pad_frame_bridge.sv
// Self-checking bench for pad_frame_bridge: directed frames plus randomized
// frames checked against a queue-based frame model and a one-cycle output model.
module tb_pad_frame_bridge;

  localparam int IN_W  = 14;
  localparam int OUT_W = 11;
  localparam int DEPTH = 32;
  localparam int LW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst;
  logic             pad_in_valid;
  logic [IN_W-1:0]  pad_in_data;
  logic             core_in_valid;
  logic [IN_W-1:0]  core_in_data;
  logic             core_in_last;
  logic             core_in_ready;
  logic             core_out_valid;
  logic [OUT_W-1:0] core_out_data;
  logic             pad_out_valid;
  logic [OUT_W-1:0] pad_out_data;
  logic [LW-1:0]    frame_len;
  logic             overflow;
  logic             protocol_err;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [IN_W-1:0]  expq [$];
  logic             exp_pov;
  logic [OUT_W-1:0] exp_pod;
  logic             stall_q;
  logic [IN_W-1:0]  stall_data;
  logic             stall_last;

  pad_frame_bridge #(
    .IN_W      (IN_W),
    .OUT_W     (OUT_W),
    .DEPTH     (DEPTH),
    .ZERO_IDLE (1'b1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pad_in_valid   (pad_in_valid),
    .pad_in_data    (pad_in_data),
    .core_in_valid  (core_in_valid),
    .core_in_data   (core_in_data),
    .core_in_last   (core_in_last),
    .core_in_ready  (core_in_ready),
    .core_out_valid (core_out_valid),
    .core_out_data  (core_out_data),
    .pad_out_valid  (pad_out_valid),
    .pad_out_data   (pad_out_data),
    .frame_len      (frame_len),
    .overflow       (overflow),
    .protocol_err   (protocol_err),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pad output model: previous cycle's core result, zero when not valid.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_pov <= 1'b0;
      exp_pod <= '0;
    end else begin
      exp_pov <= core_out_valid;
      exp_pod <= core_out_valid ? core_out_data : '0;
    end
  end

  // Per-cycle monitor: output path, word order, last flag and stall stability.
  always @(negedge clk) begin
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      check_eq("pad_out_valid", pad_out_valid, exp_pov);
      check_eq("pad_out_data", pad_out_data, exp_pod);
      if (stall_q) begin
        check_eq("hold_valid", core_in_valid, 1);
        check_eq("hold_data", core_in_data, stall_data);
        check_eq("hold_last", core_in_last, stall_last);
      end
      if (core_in_valid) begin
        if (expq.size() == 0) begin
          check_eq("spurious_core_word", core_in_valid, 0);
        end else if (core_in_ready) begin
          logic [IN_W-1:0] w;
          w = expq.pop_front();
          check_eq("core_data", core_in_data, w);
          check_eq("core_last", core_in_last, (expq.size() == 0));
        end
      end
      stall_q    = core_in_valid && !core_in_ready;
      stall_data = core_in_data;
      stall_last = core_in_last;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_cin_valid"}, core_in_valid, 0);
    check_eq({tag, "_cin_last"}, core_in_last, 0);
    check_eq({tag, "_cin_data"}, core_in_data, 0);
    check_eq({tag, "_pout_valid"}, pad_out_valid, 0);
    check_eq({tag, "_pout_data"}, pad_out_data, 0);
    check_eq({tag, "_frame_len"}, frame_len, 0);
    check_eq({tag, "_overflow"}, overflow, 0);
    check_eq({tag, "_perr"}, protocol_err, 0);
    check_eq({tag, "_busy"}, busy, 0);
  endtask

  // base >= 0 gives words base, base+1, ... and results 0x011, 0x022, ...
  task automatic run_frame(input int n, input int base, input int rmode,
                           input int nres, input bit perr_pulse, input bit rst_mid);
    int exp_len;
    int cyc;
    int accepted;
    logic [IN_W-1:0] w;
    exp_len  = (n > DEPTH) ? DEPTH : n;
    cyc      = 0;
    accepted = 0;

    for (int i = 0; i < n; i++) begin
      w = (base >= 0) ? IN_W'(base + i) : IN_W'($urandom);
      pad_in_valid = 1'b1;
      pad_in_data  = w;
      if (i < DEPTH) expq.push_back(w);
      @(negedge clk);
      check_eq(i == 0 ? "busy_at_start" : "busy_capture", busy, (i == 0) ? 0 : 1);
      check_eq("cin_valid_capture", core_in_valid, 0);
      if (i == 1) begin
        check_eq("overflow_cleared", overflow, 0);
        check_eq("perr_cleared", protocol_err, 0);
      end
      next_cycle();
    end

    pad_in_valid = 1'b0;
    pad_in_data  = IN_W'($urandom);
    @(negedge clk);
    check_eq("cin_valid_gap", core_in_valid, 0);
    check_eq("busy_gap", busy, 1);
    next_cycle();

    while (expq.size() > 0 && cyc < 400) begin
      case (rmode)
        0:       core_in_ready = 1'b1;
        1:       core_in_ready = (cyc % 3 == 0);
        default: core_in_ready = 1'($urandom_range(0, 1));
      endcase
      if (rst_mid && accepted == 2) begin
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("mid_rst");
        expq.delete();
        core_in_ready = 1'b0;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check_eq("busy_after_rst", busy, 0);
        next_cycle();
        return;
      end
      @(negedge clk);
      if (cyc == 0) begin
        check_eq("cin_valid_first", core_in_valid, 1);
        check_eq("frame_len", frame_len, exp_len);
        check_eq("overflow", overflow, (n > DEPTH));
      end
      if (core_in_valid && core_in_ready) accepted++;
      next_cycle();
      cyc++;
    end
    check_eq("drain_complete", expq.size(), 0);
    if (rmode == 0) check_eq("drain_cycles", cyc, exp_len);
    core_in_ready = 1'b0;

    if (perr_pulse) begin
      pad_in_valid = 1'b1;
      pad_in_data  = IN_W'($urandom);
      next_cycle();
      pad_in_valid = 1'b0;
      @(negedge clk);
      check_eq("perr_set", protocol_err, 1);
      check_eq("busy_after_perr", busy, 1);
      check_eq("cin_valid_after_perr", core_in_valid, 0);
      next_cycle();
    end else begin
      @(negedge clk);
      check_eq("perr_quiet", protocol_err, 0);
      check_eq("busy_wait_out", busy, 1);
      next_cycle();
    end

    for (int r = 0; r < nres; r++) begin
      core_out_valid = 1'b1;
      core_out_data  = (base >= 0) ? OUT_W'(11'h011 * (r + 1)) : OUT_W'($urandom);
      next_cycle();
    end
    core_out_valid = 1'b0;
    core_out_data  = OUT_W'($urandom);
    @(negedge clk);
    check_eq("busy_valid_fell", busy, 1);
    next_cycle();
    @(negedge clk);
    check_eq("busy_back_idle", busy, 0);
    check_eq("frame_len_held", frame_len, exp_len);
    next_cycle();
  endtask

  task automatic idle_gap();
    core_out_valid = 1'($urandom_range(0, 1));
    core_out_data  = OUT_W'($urandom);
    next_cycle();
    core_out_valid = 1'b0;
    core_out_data  = OUT_W'($urandom);
    next_cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst            = 1'b1;
    pad_in_valid   = 1'b0;
    pad_in_data    = '0;
    core_in_ready  = 1'b0;
    core_out_valid = 1'b0;
    core_out_data  = '0;
    @(negedge clk);
    check_reset_state("reset");
    next_cycle();
    rst = 1'b0;
    next_cycle();

    run_frame(5, 'h0101, 0, 3, 1'b0, 1'b0);
    idle_gap();
    run_frame(5, 'h0101, 1, 2, 1'b0, 1'b0);
    idle_gap();
    run_frame(DEPTH + 3, 'h0200, 0, 1, 1'b0, 1'b0);
    idle_gap();
    run_frame(4, 'h0300, 0, 1, 1'b0, 1'b0);
    idle_gap();
    run_frame(5, 'h0101, 0, 1, 1'b0, 1'b1);
    run_frame(3, 'h0400, 0, 1, 1'b0, 1'b0);
    idle_gap();
    run_frame(2, 'h0500, 0, 2, 1'b1, 1'b0);
    idle_gap();
    run_frame(1, 'h0600, 0, 1, 1'b0, 1'b0);
    idle_gap();

    for (int k = 0; k < 20; k++) begin
      run_frame($urandom_range(1, DEPTH + 4), -1, $urandom_range(0, 2),
                $urandom_range(1, 4), 1'($urandom_range(0, 1)), 1'b0);
      idle_gap();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
